// File: rtl/spi_slave_ctrl_fsm_if.sv
// rtl/spi_slave_ctrl_fsm_if.sv - control/status bundle between SPI conditioners, the slave FSM and its datapath
//
// Signals:
//   CS          conditioned chip select, 1 = deselected
//   sclk_rise   one-clock strobe per SPI sclk rising edge
//   read_write  R/W bit from the shift register LSB, 1 = read
//   miso_buff   MISO tri-state enable
//   dm_we       data memory write enable
//   ad_we       address latch write enable
//   sr_we       shift register parallel-load enable
//   addr_inc    address latch increment pulse (burst builds only)
//   busy        a frame is in progress
//   frame_err   one-cycle pulse on an aborted frame
// Modports: slave = the FSM, master = the surrounding logic driving it.

interface spi_slave_ctrl_fsm_if;
    logic CS;
    logic sclk_rise;
    logic read_write;
    logic miso_buff;
    logic dm_we;
    logic ad_we;
    logic sr_we;
    logic addr_inc;
    logic busy;
    logic frame_err;

    modport slave (
        input  CS, sclk_rise, read_write,
        output miso_buff, dm_we, ad_we, sr_we, addr_inc, busy, frame_err
    );

    modport master (
        output CS, sclk_rise, read_write,
        input  miso_buff, dm_we, ad_we, sr_we, addr_inc, busy, frame_err
    );
endinterface

// File: rtl/spi_slave_ctrl_fsm.sv
// rtl/spi_slave_ctrl_fsm.sv - SPI slave frame sequencer driving the address/shift/memory enables
//
// Ports:
//   s_clk    system clock, all logic on its rising edge
//   reset_n  synchronous active-low reset
//   bus      spi_slave_ctrl_fsm_if.slave (CS, sclk_rise, read_write in;
//            miso_buff, dm_we, ad_we, sr_we, addr_inc, busy, frame_err out)
// Parameters:
//   ADDR_W   address bits per command phase
//   DATA_W   data bits per data phase
// Build option:
//   SPI_BURST_EN  when defined, frames carry back-to-back data words with an
//                 address increment between them until CS deasserts.

module spi_slave_ctrl_fsm #(
    parameter  int ADDR_W   = 7,
    parameter  int DATA_W   = 8,
    localparam int CMD_BITS = ADDR_W + 1,
    localparam int MAX_BITS = (CMD_BITS > DATA_W) ? CMD_BITS : DATA_W,
    localparam int CNT_W    = $clog2(MAX_BITS + 1)
) (
    input  logic                 s_clk,
    input  logic                 reset_n,
    spi_slave_ctrl_fsm_if.slave  bus
);

    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_GET    = 3'd0,
        ST_GOT    = 3'd1,
        ST_READ   = 3'd2,
        ST_READ2  = 3'd3,
        ST_READ3  = 3'd4,
        ST_WRITE  = 3'd5,
        ST_WRITE2 = 3'd6,
        ST_DONE   = 3'd7
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             frame_err_r;
    logic             clean_idle;
    logic             no_abort;

    // Deselecting from idle or after a completed frame is a normal end.
    assign clean_idle = ((state == ST_GET) && (count == '0)) || (state == ST_DONE);

`ifdef SPI_BURST_EN
    logic addr_inc_r;
    // Sitting on a word boundary in a burst is also a legitimate place to stop.
    assign no_abort = clean_idle ||
                      (((state == ST_WRITE) || (state == ST_READ3)) && (count == '0));
`else
    assign no_abort = clean_idle;
`endif

    always_ff @(posedge s_clk) begin
        if (!reset_n) begin
            state       <= ST_GET;
            count       <= '0;
            frame_err_r <= 1'b0;
`ifdef SPI_BURST_EN
            addr_inc_r  <= 1'b0;
`endif
        end else if (bus.CS) begin
            state       <= ST_GET;
            count       <= '0;
            frame_err_r <= !no_abort;
`ifdef SPI_BURST_EN
            addr_inc_r  <= 1'b0;
`endif
        end else begin
            frame_err_r <= 1'b0;
`ifdef SPI_BURST_EN
            addr_inc_r  <= 1'b0;
`endif
            case (state)
                ST_GET: begin
                    if (bus.sclk_rise) begin
                        if (count == CMD_LAST) begin
                            state <= ST_GOT;
                            count <= '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                ST_GOT:   state <= bus.read_write ? ST_READ : ST_WRITE;
                ST_READ:  state <= ST_READ2;     // memory read latency slot
                ST_READ2: state <= ST_READ3;
                ST_READ3: begin
                    if (bus.sclk_rise) begin
                        if (count == DATA_LAST) begin
                            count <= '0;
`ifdef SPI_BURST_EN
                            state      <= ST_READ;
                            addr_inc_r <= 1'b1;  // high during the READ that fetches the next word
`else
                            state <= ST_DONE;
`endif
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (bus.sclk_rise) begin
                        if (count == DATA_LAST) begin
                            count <= '0;
                            state <= ST_WRITE2;
`ifdef SPI_BURST_EN
                            addr_inc_r <= 1'b1;  // coincides with dm_we in WRITE2
`endif
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                ST_WRITE2: begin
`ifdef SPI_BURST_EN
                    state <= ST_WRITE;
`else
                    state <= ST_DONE;
`endif
                end
                ST_DONE: state <= ST_DONE;
                default: begin
                    state <= ST_GET;
                    count <= '0;
                end
            endcase
        end
    end

    // Moore decode: each enable is high exactly while its state is current.
    assign bus.ad_we     = (state == ST_GOT);
    assign bus.sr_we     = (state == ST_READ2);
    assign bus.miso_buff = (state == ST_READ3);
    assign bus.dm_we     = (state == ST_WRITE2);
    assign bus.busy      = (state != ST_GET) || (count != '0);
    assign bus.frame_err = frame_err_r;
`ifdef SPI_BURST_EN
    assign bus.addr_inc  = addr_inc_r;
`else
    assign bus.addr_inc  = 1'b0;
`endif

endmodule
